// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch resolver: drives a subtract to the shared ALU and turns its zero flag into taken/pc_next.
// Optional BRANCH_STAT_EN adds saturating taken/not-taken statistics counters.
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        alu_req,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic [31:0] pc_next,
`ifdef BRANCH_STAT_EN
    output logic [15:0] taken_cnt,
    output logic [15:0] not_taken_cnt,
`endif
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_BEQ  = 2'b00;
    localparam logic [1:0] OP_BNE  = 2'b01;
    localparam logic [1:0] OP_BEQZ = 2'b10;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [1:0]  r_res_op;
    logic [31:0] r_pc;
    logic [15:0] r_imm;
    logic        r_flag;
    logic        r_busy;
    logic        r_done;
    logic        r_alu_req;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [31:0] r_pc_next;

    logic        w_taken;
    logic [31:0] w_seq;
    logic [31:0] w_tgt;

    // Decision for the request currently in ISSUE, straight from the ALU flag.
    always_comb begin
        w_taken = 1'b0;
        unique case (r_op)
            OP_BEQ:  w_taken = alu_zero;
            OP_BNE:  w_taken = ~alu_zero;
            OP_BEQZ: w_taken = alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_seq = r_pc + 32'd4;
    assign w_tgt = w_seq + {{14{r_imm[15]}}, r_imm, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_res_op  <= 2'b00;
            r_pc      <= 32'h0;
            r_imm     <= 16'h0;
            r_flag    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_req <= 1'b0;
            r_alu_a   <= 32'h0;
            r_alu_b   <= 32'h0;
            r_pc_next <= 32'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= S_ISSUE;
                        r_op      <= op;
                        r_pc      <= pc;
                        r_imm     <= imm;
                        r_busy    <= 1'b1;
                        r_alu_req <= 1'b1;
                        r_alu_a   <= rs_val;
                        r_alu_b   <= (op == OP_BEQZ) ? 32'h0 : rt_val;
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_DONE;
                    r_flag    <= alu_zero;
                    r_res_op  <= r_op;
                    r_pc_next <= w_taken ? w_tgt : w_seq;
                    r_done    <= 1'b1;
                    r_alu_req <= 1'b0;
                    r_alu_a   <= 32'h0;
                    r_alu_b   <= 32'h0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_alu_a   <= 32'h0;
                    r_alu_b   <= 32'h0;
                end
            endcase
        end
    end

`ifdef BRANCH_STAT_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_not_taken_cnt;

    // Counts land on the edge entering DONE; reserved ops fall into not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt     <= 16'h0;
            r_not_taken_cnt <= 16'h0;
        end else if (r_state == S_ISSUE) begin
            if (w_taken) begin
                if (r_taken_cnt != 16'hFFFF)
                    r_taken_cnt <= r_taken_cnt + 16'd1;
            end else begin
                if (r_not_taken_cnt != 16'hFFFF)
                    r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
            end
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`endif

    assign alu_req = r_alu_req;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pc_next = r_pc_next;
    assign err     = (r_res_op == 2'b11);
    assign taken   = (r_res_op == OP_BNE) ? ~r_flag :
                     (r_res_op == 2'b11)  ? 1'b0    : r_flag;

endmodule
